// File: rtl/uart_tx.sv
// UART transmitter: a valid/ready front end feeds a small FIFO, which drains into
// a start / LSB-first data / stop-bit serialiser. The line idles high.
module uart_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_RATE  = 115_200,
  parameter int CLK_FREQ   = 50_000_000,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ena,
  input  logic [DATA_WIDTH-1:0]         tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx_signal,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PULSE_WIDTH = CLK_FREQ / BAUD_RATE;
  localparam int TMR_W       = $clog2(2 * PULSE_WIDTH + 1);
  localparam int PTR_W       = $clog2(FIFO_DEPTH);
  localparam int LVL_W       = PTR_W + 1;
  localparam int CNT_W       = $clog2(DATA_WIDTH) + 1;

  localparam logic [TMR_W-1:0] BIT_LOAD  = TMR_W'(PULSE_WIDTH - 1);
  localparam logic [TMR_W-1:0] STOP_LOAD = TMR_W'(STOP_BITS * PULSE_WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
  localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                  state;
  logic [TMR_W-1:0]        timer;
  logic [CNT_W-1:0]        bit_cnt;
  logic [DATA_WIDTH-1:0]   shift;
  logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic                    fifo_empty;
  logic                    timer_done;
  logic                    push;
  logic                    pop;
  logic                    shift_en;

  assign fifo_empty = (fifo_level == '0);
  assign timer_done = (timer == '0);
  assign tx_ready   = (fifo_level != FULL_LVL);
  assign tx_busy    = (state != IDLE) | ~fifo_empty;

  // Ready comes from the registered level, so a full FIFO refuses a push even
  // while the FSM is popping; space becomes visible one cycle later.
  assign push = ena & tx_valid & tx_ready;
  assign pop  = ena & ~fifo_empty &
                ((state == IDLE) | ((state == STOP) & timer_done));
  assign shift_en = ena & timer_done &
                    ((state == START) | ((state == DATA) & (bit_cnt != LAST_BIT)));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  always_ff @(posedge clk) begin
    if (pop)           shift <= mem[rd_ptr];
    else if (shift_en) shift <= shift >> 1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else if (ena) begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // shift[0] always holds the next data bit to drive; the shift register is
  // advanced in the same edge that puts the current bit on the line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      timer     <= '0;
      bit_cnt   <= '0;
      tx_signal <= 1'b1;
    end else if (ena) begin
      case (state)
        IDLE: begin
          tx_signal <= 1'b1;
          if (!fifo_empty) begin
            tx_signal <= 1'b0;
            timer     <= BIT_LOAD;
            state     <= START;
          end
        end
        START: begin
          if (timer_done) begin
            tx_signal <= shift[0];
            bit_cnt   <= '0;
            timer     <= BIT_LOAD;
            state     <= DATA;
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        DATA: begin
          if (timer_done) begin
            if (bit_cnt == LAST_BIT) begin
              tx_signal <= 1'b1;
              timer     <= STOP_LOAD;
              state     <= STOP;
            end else begin
              tx_signal <= shift[0];
              bit_cnt   <= bit_cnt + CNT_W'(1);
              timer     <= BIT_LOAD;
            end
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        STOP: begin
          if (timer_done) begin
            if (!fifo_empty) begin
              tx_signal <= 1'b0;
              timer     <= BIT_LOAD;
              state     <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        default: begin
          tx_signal <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: accepted words go into a scoreboard queue; a line monitor
// rebuilds each frame from enabled-cycle samples and compares against it.
module tb_uart_tx;

  localparam int DW    = 8;
  localparam int PW    = 10;
  localparam int FRAME = (1 + DW + 1) * PW;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ena = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_signal, tx_busy;
  logic [2:0] fifo_level;

  logic       ena2 = 1'b1;
  logic [7:0] tx_data2 = 8'h00;
  logic       tx_valid2 = 1'b0;
  logic       tx_ready2, tx_signal2, tx_busy2;
  logic [2:0] fifo_level2;

  int checks = 0;
  int errors = 0;

  logic [7:0]  exp_q[$];
  int unsigned starts[$];
  int unsigned ecnt = 0;
  bit          mon_act = 1'b0;
  bit          mon_unexp = 1'b0;
  int          mon_n = 0;
  int          mon_bad = 0;
  logic [7:0]  mon_exp = 8'h00;
  logic [7:0]  mon_word = 8'h00;

  always #5 clk = ~clk;

  uart_tx #(.DATA_WIDTH(8), .BAUD_RATE(100_000), .CLK_FREQ(1_000_000),
            .STOP_BITS(1), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .ena(ena), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_signal(tx_signal), .tx_busy(tx_busy),
    .fifo_level(fifo_level));

  uart_tx #(.DATA_WIDTH(8), .BAUD_RATE(100_000), .CLK_FREQ(1_000_000),
            .STOP_BITS(2), .FIFO_DEPTH(4)) dut2 (
    .clk(clk), .reset(reset), .ena(ena2), .tx_data(tx_data2), .tx_valid(tx_valid2),
    .tx_ready(tx_ready2), .tx_signal(tx_signal2), .tx_busy(tx_busy2),
    .fifo_level(fifo_level2));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tmo(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected line level for bit slot b of a frame carrying word w.
  function automatic logic exp_line(input logic [7:0] w, input int b);
    if (b == 0) return 1'b0;
    if (b <= DW) return w[b-1];
    return 1'b1;
  endfunction

  task automatic push(input logic [7:0] w);
    bit acc = 1'b0;
    int n = 0;
    tx_data  = w;
    tx_valid = 1'b1;
    while (!acc && n < 2000) begin
      @(posedge clk);
      acc = ena && tx_ready;
      n++;
    end
    #1 tx_valid = 1'b0;
    if (!acc) tmo("push_accept");
  endtask

  task automatic wait_fall();
    int n = 0;
    @(negedge clk);
    while (tx_signal && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (tx_signal) tmo("start_bit");
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((tx_busy || mon_act || exp_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) tmo("drain");
  endtask

  // Scoreboard producer: every accepted word is expected on the line, in order.
  initial forever begin
    @(posedge clk);
    if (!reset && ena && tx_valid && tx_ready) exp_q.push_back(tx_data);
  end

  task automatic mon_step();
    int b;
    if (reset) begin
      mon_act = 1'b0;
      exp_q.delete();
      return;
    end
    if (!ena) return;
    ecnt++;
    if (!mon_act && tx_signal == 1'b0) begin
      starts.push_back(ecnt);
      mon_act  = 1'b1;
      mon_n    = 0;
      mon_bad  = 0;
      mon_word = 8'h00;
      if (exp_q.size() == 0) begin
        mon_unexp = 1'b1;
        mon_exp   = 8'h00;
        checks++;
        errors++;
        $display("FAIL frame_unexpected: start bit at sample %0d with nothing queued", ecnt);
      end else begin
        mon_unexp = 1'b0;
        mon_exp   = exp_q.pop_front();
      end
    end
    if (mon_act) begin
      b = mon_n / PW;
      if (tx_signal !== exp_line(mon_exp, b)) mon_bad++;
      if ((mon_n % PW) == PW / 2 && b >= 1 && b <= DW) mon_word[b-1] = tx_signal;
      mon_n++;
      if (mon_n == FRAME) begin
        mon_act = 1'b0;
        if (!mon_unexp) begin
          chk("frame_word", int'(mon_word), int'(mon_exp));
          chk("frame_wave_bad_samples", mon_bad, 0);
        end
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    mon_step();
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not complete, %0d checks so far", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] words [6];
    int fi, n, maxl, rbad, bad, run;
    bit acc;
    logic hold, ev;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_tx_signal", tx_signal, 1);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_tx_busy", tx_busy, 0);
    chk("rst_fifo_level", fifo_level, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) tick();

    // Single word: latency, frame length on tx_busy
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    @(negedge clk);
    chk("single_line_before_fall", tx_signal, 1);
    chk("single_level_after_push", fifo_level, 1);
    @(negedge clk);
    chk("single_fall_latency", tx_signal, 0);
    chk("single_level_after_pop", fifo_level, 0);
    n = 0;
    while (tx_busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("single_busy_cycles", n, 100);
    wait_idle();

    // Back-to-back words on consecutive edges
    starts.delete();
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_data = 8'hFF;
    @(negedge clk);
    chk("b2b_level_0", fifo_level, 1);
    @(posedge clk);
    #1 tx_data = 8'h55;
    @(negedge clk);
    chk("b2b_level_1", fifo_level, 1);
    @(posedge clk);
    #1 tx_valid = 1'b0;
    @(negedge clk);
    chk("b2b_level_2", fifo_level, 2);
    wait_idle();
    chk("b2b_frames", starts.size(), 3);
    if (starts.size() == 3) begin
      chk("b2b_gap_1", int'(starts[1] - starts[0]), FRAME);
      chk("b2b_gap_2", int'(starts[2] - starts[1]), FRAME);
    end
    tick();

    // FIFO full: valid held continuously over six distinct random words
    for (int i = 0; i < 6; i++) words[i] = 8'(i) | 8'($urandom_range(0, 31) << 3);
    fi = 0; n = 0; maxl = 0; rbad = 0;
    tx_valid = 1'b1;
    while (fi < 6 && n < 3000) begin
      tx_data = words[fi];
      @(posedge clk);
      n++;
      if (int'(fifo_level) > maxl) maxl = int'(fifo_level);
      if ((fifo_level == 3'd4) == tx_ready) rbad++;
      acc = tx_ready;
      #1;
      if (acc) fi++;
    end
    tx_valid = 1'b0;
    if (fi < 6) tmo("full_feed");
    chk("full_max_level", maxl, 4);
    chk("full_ready_mismatch_cycles", rbad, 0);
    wait_idle();
    tick();

    // ena held low for 7 cycles in the middle of a data bit
    push(8'h55);
    wait_fall();
    repeat (35) tick();
    hold = tx_signal;
    bad  = 0;
    ena  = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (tx_signal !== hold) bad++;
      @(posedge clk);
      #1;
    end
    ena = 1'b1;
    chk("ena_hold_changes", bad, 0);
    wait_idle();
    tick();

    // Reset in the middle of a frame with two words queued
    push(8'h11);
    push(8'h22);
    push(8'h33);
    wait_fall();
    repeat (35) tick();
    chk("rst_mid_level_before", fifo_level, 2);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_tx_signal", tx_signal, 1);
    chk("rst_mid_fifo_level", fifo_level, 0);
    chk("rst_mid_tx_ready", tx_ready, 1);
    chk("rst_mid_tx_busy", tx_busy, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) tick();
    chk("rst_release_line_idle", tx_signal, 1);
    push(8'h81);
    wait_idle();
    tick();

    // Random words, random gaps, random ena drops between pushes
    for (int k = 0; k < 8; k++) begin
      n = $urandom_range(0, 30);
      for (int g = 0; g < n; g++) begin
        ena = ($urandom_range(0, 5) != 0);
        tick();
      end
      ena = 1'b1;
      push(8'($urandom));
    end
    ena = 1'b1;
    wait_idle();

    // Two stop bits on the second instance: 0x3C followed by 0xC3
    tx_data2  = 8'h3C;
    tx_valid2 = 1'b1;
    tick();
    tx_data2 = 8'hC3;
    tick();
    tx_valid2 = 1'b0;
    n = 0;
    @(negedge clk);
    while (tx_signal2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (tx_signal2) tmo("sb2_start_bit");
    bad = 0;
    run = 0;
    for (int s = 0; s <= 110; s++) begin
      if (s < 10)       ev = 1'b0;
      else if (s < 90)  ev = exp_line(8'h3C, s / 10);
      else if (s < 110) ev = 1'b1;
      else              ev = 1'b0;
      if (tx_signal2 !== ev) bad++;
      if (s < 110) run = tx_signal2 ? run + 1 : 0;
      if (s < 110) @(negedge clk);
    end
    chk("sb2_wave_bad_samples", bad, 0);
    chk("sb2_stop_high_cycles", run, 20);
    n = 0;
    while (tx_busy2 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("sb2_busy_after", tx_busy2, 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
